// File: rtl/register_file_sb_if.sv
// register_file_sb_if: decode/writeback bus for register_file_sb (read ports, write port, scoreboard lock).
interface register_file_sb_if #(parameter int DATA_W = 16, parameter int ADDR_W = 4);
    logic              reg1_read;
    logic [ADDR_W-1:0] reg1_addr;
    logic [DATA_W-1:0] reg1_bus;
    logic              reg1_busy;
    logic              reg2_read;
    logic [ADDR_W-1:0] reg2_addr;
    logic [DATA_W-1:0] reg2_bus;
    logic              reg2_busy;
    logic              reg3_write;
    logic [ADDR_W-1:0] reg3_addr;
    logic [DATA_W-1:0] reg3_bus;
    logic              lock_req;
    logic [ADDR_W-1:0] lock_addr;
    logic              lock_err;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output reg1_read, reg1_addr, reg2_read, reg2_addr,
               reg3_write, reg3_addr, reg3_bus, lock_req, lock_addr,
        input  reg1_bus, reg1_busy, reg2_bus, reg2_busy, lock_err, busy_cnt
    );

    modport slave (
        input  reg1_read, reg1_addr, reg2_read, reg2_addr,
               reg3_write, reg3_addr, reg3_bus, lock_req, lock_addr,
        output reg1_bus, reg1_busy, reg2_bus, reg2_busy, lock_err, busy_cnt
    );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb: 2R/1W register file with registered tri-state reads and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards a same-edge write into the read ports.
module register_file_sb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    register_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W:0]   cnt;
    logic              lock_err_q;
    logic              inc;
    logic              dec;
    logic [1:0]              rd;
    logic [1:0][ADDR_W-1:0]  ra;

    assign rd = {bus.reg2_read, bus.reg1_read};
    assign ra = {bus.reg2_addr, bus.reg1_addr};

    // A same-edge lock on the written register keeps it busy, so no decrement then
    assign inc = bus.lock_req && !busy[bus.lock_addr];
    assign dec = bus.reg3_write && busy[bus.reg3_addr] &&
                 !(bus.lock_req && bus.lock_addr == bus.reg3_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy       <= '0;
            cnt        <= '0;
            lock_err_q <= 1'b0;
        end else begin
            if (bus.reg3_write) begin
                mem[bus.reg3_addr]  <= bus.reg3_bus;
                busy[bus.reg3_addr] <= 1'b0;
            end
            if (bus.lock_req) busy[bus.lock_addr] <= 1'b1;
            cnt        <= cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
            lock_err_q <= bus.lock_req && busy[bus.lock_addr];
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [DATA_W-1:0] dn;
        logic              bn;
        logic [DATA_W-1:0] dq;
        logic              bq;
        logic              vq;
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd = bus.reg3_write && ra[p] == bus.reg3_addr;
        always_comb begin
            dn = fwd ? bus.reg3_bus : mem[ra[p]];
            bn = fwd ? (bus.lock_req && bus.lock_addr == ra[p]) : busy[ra[p]];
        end
`else
        always_comb begin
            dn = mem[ra[p]];
            bn = busy[ra[p]];
        end
`endif
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dq <= '0;
                bq <= 1'b0;
                vq <= 1'b0;
            end else begin
                vq <= rd[p];
                if (rd[p]) begin
                    dq <= dn;
                    bq <= bn;
                end
            end
        end
    end

    assign bus.reg1_bus  = g_rd[0].vq ? g_rd[0].dq : 'z;
    assign bus.reg2_bus  = g_rd[1].vq ? g_rd[1].dq : 'z;
    assign bus.reg1_busy = g_rd[0].bq & g_rd[0].vq;
    assign bus.reg2_busy = g_rd[1].bq & g_rd[1].vq;
    assign bus.lock_err  = lock_err_q;
    assign bus.busy_cnt  = cnt;
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed self-checking bench for register_file_sb.
// Honours REGFILE_BYPASS_EN for the same-edge read/write case.
module tb_register_file_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    register_file_sb_if #(.DATA_W(16), .ADDR_W(4)) bus ();
    register_file_sb #(.DATA_W(16), .ADDR_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.reg1_read = 0; bus.reg2_read = 0; bus.reg3_write = 0; bus.lock_req = 0;
    endtask

    initial begin
        logic [15:0] hz;
        logic [15:0] exp7;
        hz = 16'hzzzz;
        bus.reg1_addr = 0; bus.reg2_addr = 0; bus.reg3_addr = 0; bus.reg3_bus = 0; bus.lock_addr = 0;
        idle();
        repeat (2) tick();
        chk("rst_bus1", bus.reg1_bus, hz);
        chk("rst_bus2", bus.reg2_bus, hz);
        chk("rst_cnt", bus.busy_cnt, 0);
        chk("rst_lock_err", bus.lock_err, 0);
        chk("rst_busy1", bus.reg1_busy, 0);
        rst_n = 1;
        // 1: fill and read back
        for (int i = 0; i < 16; i++) begin
            bus.reg3_write = 1; bus.reg3_addr = 4'(i); bus.reg3_bus = 16'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            bus.reg1_read = 1; bus.reg1_addr = 4'(i);
            bus.reg2_read = 1; bus.reg2_addr = 4'(i);
            tick();
            chk("rd_p1", bus.reg1_bus, 16'(i));
            chk("rd_p2", bus.reg2_bus, 16'(i));
        end
        idle();
        tick();
        chk("idle_p1", bus.reg1_bus, hz);
        chk("idle_p2", bus.reg2_bus, hz);
        // 2: lock, stale read, write clears
        bus.lock_req = 1; bus.lock_addr = 5;
        tick();
        idle();
        chk("lock5_cnt", bus.busy_cnt, 1);
        bus.reg1_read = 1; bus.reg1_addr = 5;
        tick();
        idle();
        chk("lock5_busy", bus.reg1_busy, 1);
        chk("lock5_stale", bus.reg1_bus, 16'h0005);
        bus.reg3_write = 1; bus.reg3_addr = 5; bus.reg3_bus = 16'hBEEF;
        tick();
        idle();
        chk("wr5_cnt", bus.busy_cnt, 0);
        bus.reg1_read = 1; bus.reg1_addr = 5;
        tick();
        idle();
        chk("wr5_data", bus.reg1_bus, 16'hBEEF);
        chk("wr5_busy", bus.reg1_busy, 0);
        // 3: same-edge read and write
        bus.reg2_read = 1; bus.reg2_addr = 7;
        bus.reg3_write = 1; bus.reg3_addr = 7; bus.reg3_bus = 16'h1234;
        tick();
        idle();
`ifdef REGFILE_BYPASS_EN
        exp7 = 16'h1234;
`else
        exp7 = 16'h0007;
`endif
        chk("rw7_same_edge", bus.reg2_bus, exp7);
        chk("rw7_busy", bus.reg2_busy, 0);
        bus.reg2_read = 1; bus.reg2_addr = 7;
        tick();
        idle();
        chk("rw7_next", bus.reg2_bus, 16'h1234);
        // 4: double lock and lock+write
        bus.lock_req = 1; bus.lock_addr = 3;
        tick();
        chk("lock3a_err", bus.lock_err, 0);
        chk("lock3a_cnt", bus.busy_cnt, 1);
        tick();
        idle();
        chk("lock3b_err", bus.lock_err, 1);
        chk("lock3b_cnt", bus.busy_cnt, 1);
        tick();
        chk("lock3_err_clr", bus.lock_err, 0);
        bus.lock_req = 1; bus.lock_addr = 3;
        bus.reg3_write = 1; bus.reg3_addr = 3; bus.reg3_bus = 16'h0333;
        tick();
        idle();
        chk("lockwr3_cnt", bus.busy_cnt, 1);
        chk("lockwr3_err", bus.lock_err, 1);
        bus.reg1_read = 1; bus.reg1_addr = 3;
        tick();
        idle();
        chk("lockwr3_busy", bus.reg1_busy, 1);
        chk("lockwr3_data", bus.reg1_bus, 16'h0333);
        bus.reg3_write = 1; bus.reg3_addr = 3; bus.reg3_bus = 16'h0003;
        tick();
        idle();
        chk("wr3_cnt", bus.busy_cnt, 0);
        // 5: lock everything, then async reset mid-read
        for (int i = 0; i < 16; i++) begin
            bus.lock_req = 1; bus.lock_addr = 4'(i);
            tick();
            chk("lockall_cnt", bus.busy_cnt, i + 1);
        end
        idle();
        bus.reg1_read = 1; bus.reg1_addr = 9;
        bus.reg2_read = 1; bus.reg2_addr = 10;
        tick();
        chk("pre_rst_p1", bus.reg1_bus, 16'h0009);
        chk("pre_rst_busy1", bus.reg1_busy, 1);
        chk("pre_rst_p2", bus.reg2_bus, 16'h000A);
        #2 rst_n = 0;
        #1;
        chk("async_rst_p1", bus.reg1_bus, hz);
        chk("async_rst_p2", bus.reg2_bus, hz);
        chk("async_rst_cnt", bus.busy_cnt, 0);
        chk("async_rst_busy2", bus.reg2_busy, 0);
        idle();
        tick();
        rst_n = 1;
        for (int i = 0; i < 16; i++) begin
            bus.reg1_read = 1; bus.reg1_addr = 4'(i);
            bus.reg2_read = 1; bus.reg2_addr = 4'(15 - i);
            tick();
            chk("post_rst_p1", bus.reg1_bus, 0);
            chk("post_rst_p2", bus.reg2_bus, 0);
            chk("post_rst_busy1", bus.reg1_busy, 0);
        end
        idle();
        // 6: consecutive writes, last wins
        bus.reg3_write = 1; bus.reg3_addr = 9; bus.reg3_bus = 16'hAAAA;
        tick();
        bus.reg3_bus = 16'h5555;
        tick();
        idle();
        bus.reg1_read = 1; bus.reg1_addr = 9;
        bus.reg2_read = 1; bus.reg2_addr = 9;
        tick();
        idle();
        chk("ww9_p1", bus.reg1_bus, 16'h5555);
        chk("ww9_p2", bus.reg2_bus, 16'h5555);
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
